lif_potential_integrator: RTL and testbench

//   Sequential membrane-potential stage of a leaky integrate-and-fire neuron.
//   Per time step: applies leak, then accumulates a stream of signed synaptic weights with

---
 rtl/lif_potential_integrator.sv | 103 ++++++++++
 tb/tb_lif_potential_integrator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_potential_integrator.sv
// Membrane-potential stage of a leaky integrate-and-fire neuron.
// Each time step applies the leak, then accumulates synaptic weights, then fires and enters refractory.
module lif_potential_integrator #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             syn_valid_i,
  output logic             syn_ready_o,
  input  logic [DSIZE-1:0] syn_weight_i,
  input  logic             syn_last_i,
  input  logic [DSIZE-1:0] leak_i,
  input  logic [DSIZE-1:0] threshold_i,
  input  logic [DSIZE-1:0] rest_i,
  input  logic [RSIZE-1:0] refrac_len_i,
  output logic [DSIZE-1:0] potential_o,
  output logic             spike_o,
  output logic             step_done_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAK  = 2'd1,
    INTEG = 2'd2,
    FIRE  = 2'd3
  } state_t;

  localparam logic signed [DSIZE-1:0] MAX_VAL = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic signed [DSIZE-1:0] MIN_VAL = {1'b1, {(DSIZE-1){1'b0}}};

  state_t                  state;
  logic signed [DSIZE-1:0] potential;
  logic [RSIZE-1:0]        refrac_cnt;

  // Overflow shows as the extra sign bit disagreeing with the result's sign bit.
  function automatic logic signed [DSIZE-1:0] sat_add(input logic signed [DSIZE-1:0] a,
                                                      input logic signed [DSIZE-1:0] b);
    logic signed [DSIZE:0] s;
    s = {a[DSIZE-1], a} + {b[DSIZE-1], b};
    if (s[DSIZE] != s[DSIZE-1]) return s[DSIZE] ? MIN_VAL : MAX_VAL;
    return s[DSIZE-1:0];
  endfunction

  function automatic logic signed [DSIZE-1:0] sat_sub(input logic signed [DSIZE-1:0] a,
                                                      input logic signed [DSIZE-1:0] b);
    logic signed [DSIZE:0] s;
    s = {a[DSIZE-1], a} - {b[DSIZE-1], b};
    if (s[DSIZE] != s[DSIZE-1]) return s[DSIZE] ? MIN_VAL : MAX_VAL;
    return s[DSIZE-1:0];
  endfunction

  // Weight handshake: a weight is consumed on a rising edge where syn_valid_i and
  // syn_ready_o are both high; syn_ready_o is high only in INTEG and never depends on valid.
  assign syn_ready_o = (state == INTEG);
  assign busy_o      = (state != IDLE);
  assign potential_o = potential;
  assign state_o     = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      potential   <= '0;
      refrac_cnt  <= '0;
      spike_o     <= 1'b0;
      step_done_o <= 1'b0;
    end else begin
      spike_o     <= 1'b0;
      step_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (step_i) state <= LEAK;
        end
        LEAK: begin
          if (refrac_cnt == '0) potential <= sat_sub(potential, $signed(leak_i));
          state <= INTEG;
        end
        INTEG: begin
          if (syn_valid_i) begin
            if (refrac_cnt == '0) potential <= sat_add(potential, $signed(syn_weight_i));
            if (syn_last_i) state <= FIRE;
          end
        end
        FIRE: begin
          if (refrac_cnt == '0 && potential >= $signed(threshold_i)) begin
            potential  <= $signed(rest_i);
            refrac_cnt <= refrac_len_i;
            spike_o    <= 1'b1;
          end else if (refrac_cnt != '0) begin
            refrac_cnt <= refrac_cnt - 1'b1;
          end
          step_done_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_potential_integrator.sv
// Directed bench for lif_potential_integrator: a step-level neuron model drives per-cycle
// expectations that one negedge process compares, plus hand-computed literal checks.
module tb_lif_potential_integrator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        step_i;
  logic        syn_valid_i;
  logic        syn_ready_o;
  logic [15:0] syn_weight_i;
  logic        syn_last_i;
  logic [15:0] leak_i;
  logic [15:0] threshold_i;
  logic [15:0] rest_i;
  logic [3:0]  refrac_len_i;
  logic [15:0] potential_o;
  logic        spike_o;
  logic        step_done_o;
  logic        busy_o;
  logic [1:0]  dbg_state;

  int leak_v, thr_v, rest_v, rl_v, w_v;
  assign leak_i       = leak_v[15:0];
  assign threshold_i  = thr_v[15:0];
  assign rest_i       = rest_v[15:0];
  assign refrac_len_i = rl_v[3:0];
  assign syn_weight_i = w_v[15:0];

  lif_potential_integrator #(.DSIZE(16), .RSIZE(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .step_i(step_i),
    .syn_valid_i(syn_valid_i), .syn_ready_o(syn_ready_o), .syn_weight_i(syn_weight_i),
    .syn_last_i(syn_last_i), .leak_i(leak_i), .threshold_i(threshold_i), .rest_i(rest_i),
    .refrac_len_i(refrac_len_i), .potential_o(potential_o), .spike_o(spike_o),
    .step_done_o(step_done_o), .busy_o(busy_o), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, maintained by the driver tasks.
  int m_pot = 0, m_refrac = 0;
  bit m_spike = 0, m_done = 0, m_ready = 0, m_busy = 0;
  bit cmp_en = 0;
  int checks = 0, failures = 0;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("potential", $signed(potential_o), m_pot);
      chk("spike", spike_o, m_spike);
      chk("step_done", step_done_o, m_done);
      chk("syn_ready", syn_ready_o, m_ready);
      chk("busy", busy_o, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full time step with up to three weights; gap idle cycles precede each weight,
  // and poke pulses step_i during the first gap cycle (must be ignored).
  task automatic do_step(input int w0, input int w1, input int w2, input int n,
                         input int gap, input bit poke,
                         output int pre_fire, output bit spiked, output int post_fire);
    int w[3];
    w = '{w0, w1, w2};
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    m_busy = 1'b1;
    tick();
    if (m_refrac == 0) m_pot = sat(m_pot - leak_v);
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        syn_valid_i = 1'b0;
        step_i = poke && (g == 0);
        w_v = 777;
        tick();
        step_i = 1'b0;
      end
      syn_valid_i = 1'b1;
      w_v = w[i];
      syn_last_i = (i == n - 1);
      tick();
      if (m_refrac == 0) m_pot = sat(m_pot + w[i]);
      if (i == n - 1) m_ready = 1'b0;
      syn_valid_i = 1'b0;
      syn_last_i = 1'b0;
    end
    pre_fire = $signed(potential_o);
    tick();
    if (m_refrac == 0 && m_pot >= thr_v) begin
      m_pot = rest_v;
      m_refrac = rl_v;
      m_spike = 1'b1;
    end else if (m_refrac != 0) begin
      m_refrac--;
    end
    m_done = 1'b1;
    m_busy = 1'b0;
    spiked = spike_o;
    post_fire = $signed(potential_o);
    tick();
    m_spike = 1'b0;
    m_done = 1'b0;
  endtask

  int pre, post;
  bit sp;

  initial begin
    rst_i = 1'b1; step_i = 1'b0; syn_valid_i = 1'b0; syn_last_i = 1'b0;
    w_v = 0; leak_v = 0; thr_v = 0; rest_v = 0; rl_v = 0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("reset_potential", $signed(potential_o), 0);
    chk("reset_spike", spike_o, 0);
    chk("reset_done", step_done_o, 0);
    chk("reset_ready", syn_ready_o, 0);
    tick();

    // Fire: -1, 29, 69, 109 -> spike, potential back to rest.
    thr_v = 100; leak_v = 1; rest_v = 0; rl_v = 2;
    do_step(30, 40, 40, 3, 0, 1'b0, pre, sp, post);
    chk("fire_pre", pre, 109);
    chk("fire_spike", sp, 1);
    chk("fire_post", post, 0);

    // Refractory: two suppressed steps, then firing resumes.
    do_step(200, 0, 0, 1, 0, 1'b0, pre, sp, post);
    chk("refrac1_pot", pre, 0);
    chk("refrac1_spike", sp, 0);
    do_step(200, 0, 0, 1, 0, 1'b0, pre, sp, post);
    chk("refrac2_pot", pre, 0);
    chk("refrac2_spike", sp, 0);
    rl_v = 0;
    do_step(200, 0, 0, 1, 0, 1'b0, pre, sp, post);
    chk("refrac3_pot", pre, 199);
    chk("refrac3_spike", sp, 1);

    // Saturation at both rails.
    leak_v = 0; thr_v = 32767; rest_v = 0;
    do_step(28672, 28672, 0, 2, 0, 1'b0, pre, sp, post);
    chk("sat_pos_pot", pre, 32767);
    chk("sat_pos_spike", sp, 1);
    do_step(-28672, -28672, 0, 2, 0, 1'b0, pre, sp, post);
    chk("sat_neg_pot", pre, -32768);
    chk("sat_neg_spike", sp, 0);

    // Weights offered while idle are not consumed.
    syn_valid_i = 1'b1; syn_last_i = 1'b1; w_v = 500;
    repeat (3) tick();
    syn_valid_i = 1'b0; syn_last_i = 1'b0;
    chk("idle_weights_pot", $signed(potential_o), -32768);

    // Valid gaps and a stray step_i during INTEG.
    do_step(100, 200, 0, 2, 2, 1'b1, pre, sp, post);
    chk("flow_pot", pre, -32468);
    chk("flow_spike", sp, 0);
    tick();
    chk("flow_idle_after", busy_o, 0);

    // Reset in the middle of INTEG.
    thr_v = 100;
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    m_busy = 1'b1;
    tick();
    m_ready = 1'b1;
    syn_valid_i = 1'b1; w_v = 50;
    tick();
    m_pot = sat(m_pot + 50);
    syn_valid_i = 1'b0;
    chk("mid_integ_pot", $signed(potential_o), -32418);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_pot = 0; m_refrac = 0; m_ready = 1'b0; m_busy = 1'b0;
    chk("midrst_pot", $signed(potential_o), 0);
    chk("midrst_busy", busy_o, 0);
    repeat (3) tick();

    // Normal operation resumes after the reset.
    rl_v = 0;
    do_step(150, 0, 0, 1, 0, 1'b0, pre, sp, post);
    chk("recover_pot", pre, 150);
    chk("recover_spike", sp, 1);
    repeat (2) tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
